// File: rtl/bit_serializer.sv
// bit_serializer
//   Parallel-to-serial converter feeding the downstream even/majority-ones
//   detector. Words arrive over a valid/ready handshake and leave one bit per
//   clk on ser_out. A frame is WIDTH data bits, optionally followed by one
//   even-parity bit. A frame may be followed by GAP_CYCLES idle cycles.
//
//   Optional feature: define EVEN_PARITY_EN to append an even-parity bit
//   (XOR of the word) after the data bits. The frame then becomes WIDTH+1
//   bits long, and word_done falls on the parity cycle.
//
// Ports
//   clk        clock, all state on the rising edge
//   rst        asynchronous, active-high reset
//   in_data    parallel word, sampled only on accept
//   in_valid   in_data valid
//   in_ready   block can accept this cycle (combinational)
//   ser_out    serial bit (registered); IDLE_LEVEL when ser_valid=0
//   ser_valid  ser_out carries a frame bit (registered)
//   word_done  high while the last frame bit is on ser_out
//   busy       FSM not in IDLE
module bit_serializer #(
   parameter int WIDTH      = 8,
   parameter int MSB_FIRST  = 1,
   parameter bit IDLE_LEVEL = 1'b0,
   parameter int GAP_CYCLES = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             word_done,
   output logic             busy
);

   // Bit counter holds 0..WIDTH; gap counter holds 0..GAP_CYCLES (min 1 bit).
   localparam int CW = $clog2(WIDTH + 2);
   localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH);
   localparam logic [GW-1:0] LAST_GAP = GW'(GAP_CYCLES);

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("bit_serializer: WIDTH must be in 2..32");
   end
   if (GAP_CYCLES < 0 || GAP_CYCLES > 255) begin : g_bad_gap
      $error("bit_serializer: GAP_CYCLES must be in 0..255");
   end
   if (MSB_FIRST != 0 && MSB_FIRST != 1) begin : g_bad_order
      $error("bit_serializer: MSB_FIRST must be 0 or 1");
   end

`ifdef EVEN_PARITY_EN
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY, GAP} state_t;
`else
   typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sr_q, sr_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
   logic             ser_out_q, ser_out_d;
   logic             ser_valid_q, ser_valid_d;
`ifdef EVEN_PARITY_EN
   logic             par_q, par_d;
`endif

   logic last_bit;
   logic accept;
   logic ld;    // load a new word this cycle
   logic fin;   // last frame bit is leaving ser_out this cycle

   // Bit that goes out next, and the register after it has been consumed.
   function automatic logic head(input logic [WIDTH-1:0] w);
      return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
   endfunction

`ifdef EVEN_PARITY_EN
   assign last_bit = (state_q == PARITY);
`else
   assign last_bit = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
`endif

   // With no gap, a new word may be taken on the edge that retires the last
   // bit, so frames run back-to-back without a ser_valid bubble.
   assign in_ready  = (state_q == IDLE) | ((GAP_CYCLES == 0) & last_bit);
   assign accept    = in_valid & in_ready;
   assign ser_out   = ser_out_q;
   assign ser_valid = ser_valid_q;
   assign word_done = ser_valid_q & last_bit;
   assign busy      = (state_q != IDLE);

   // Next-state and next-output logic. Outputs are registered, so every
   // *_d value describes what appears on the pins in the following cycle.
   always_comb begin
      state_d     = state_q;
      sr_d        = sr_q;
      bit_cnt_d   = bit_cnt_q;
      gap_cnt_d   = gap_cnt_q;
      ser_out_d   = IDLE_LEVEL;
      ser_valid_d = 1'b0;
`ifdef EVEN_PARITY_EN
      par_d       = par_q;
`endif
      ld          = 1'b0;
      fin         = 1'b0;

      case (state_q)
         IDLE: ld = accept;
         SHIFT: begin
            if (bit_cnt_q != LAST_BIT) begin
               ser_out_d   = head(sr_q);
               ser_valid_d = 1'b1;
               sr_d        = advance(sr_q);
               bit_cnt_d   = bit_cnt_q + CW'(1);
            end else begin
`ifdef EVEN_PARITY_EN
               state_d     = PARITY;
               ser_out_d   = par_q;
               ser_valid_d = 1'b1;
`else
               fin = 1'b1;
`endif
            end
         end
`ifdef EVEN_PARITY_EN
         PARITY: fin = 1'b1;
`endif
         GAP: begin
            if (gap_cnt_q == LAST_GAP) begin
               state_d   = IDLE;
               gap_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + GW'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Frame exit: into the gap if there is one, else straight to the next
      // word (only possible when GAP_CYCLES==0, since in_ready needs it).
      if (fin) begin
         bit_cnt_d = '0;
         if (GAP_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = GW'(1);
         end else begin
            state_d = IDLE;
            ld      = accept;
         end
      end

      if (ld) begin
         state_d     = SHIFT;
         ser_out_d   = head(in_data);
         ser_valid_d = 1'b1;
         sr_d        = advance(in_data);
         bit_cnt_d   = CW'(1);
`ifdef EVEN_PARITY_EN
         par_d       = ^in_data;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         sr_q        <= '0;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         ser_out_q   <= IDLE_LEVEL;
         ser_valid_q <= 1'b0;
`ifdef EVEN_PARITY_EN
         par_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         sr_q        <= sr_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         ser_out_q   <= ser_out_d;
         ser_valid_q <= ser_valid_d;
`ifdef EVEN_PARITY_EN
         par_q       <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer. Three instances share clk/rst:
//   u_a  MSB first, one gap cycle
//   u_b  MSB first, no gap (back-to-back streaming)
//   u_c  LSB first, one gap cycle
// Expected bit streams are written out by hand; parity bits are appended
// when EVEN_PARITY_EN is defined.
module tb_bit_serializer;

`ifdef EVEN_PARITY_EN
   localparam int FL = 9;
`else
   localparam int FL = 8;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] a_data = '0, b_data = '0, c_data = '0;
   logic       a_valid = 1'b0, b_valid = 1'b0, c_valid = 1'b0;
   logic       a_rdy, a_so, a_sv, a_wd, a_busy;
   logic       b_rdy, b_so, b_sv, b_wd, b_busy;
   logic       c_rdy, c_so, c_sv, c_wd, c_busy;

   int         n_chk = 0;
   int         n_err = 0;
   int         sel = 0;
   logic       o_rdy, o_so, o_sv, o_wd, o_busy;

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0), .GAP_CYCLES(1)) u_a (
      .clk(clk), .rst(rst), .in_data(a_data), .in_valid(a_valid), .in_ready(a_rdy),
      .ser_out(a_so), .ser_valid(a_sv), .word_done(a_wd), .busy(a_busy));

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1), .IDLE_LEVEL(1'b0), .GAP_CYCLES(0)) u_b (
      .clk(clk), .rst(rst), .in_data(b_data), .in_valid(b_valid), .in_ready(b_rdy),
      .ser_out(b_so), .ser_valid(b_sv), .word_done(b_wd), .busy(b_busy));

   bit_serializer #(.WIDTH(8), .MSB_FIRST(0), .IDLE_LEVEL(1'b0), .GAP_CYCLES(1)) u_c (
      .clk(clk), .rst(rst), .in_data(c_data), .in_valid(c_valid), .in_ready(c_rdy),
      .ser_out(c_so), .ser_valid(c_sv), .word_done(c_wd), .busy(c_busy));

   // Observation mux so one frame checker serves every instance.
   always_comb begin
      {o_rdy, o_so, o_sv, o_wd, o_busy} = {a_rdy, a_so, a_sv, a_wd, a_busy};
      case (sel)
         1: {o_rdy, o_so, o_sv, o_wd, o_busy} = {b_rdy, b_so, b_sv, b_wd, b_busy};
         2: {o_rdy, o_so, o_sv, o_wd, o_busy} = {c_rdy, c_so, c_sv, c_wd, c_busy};
         default: ;
      endcase
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".sv"},   o_sv,   1'b0);
      chk({tag, ".so"},   o_so,   1'b0);
      chk({tag, ".wd"},   o_wd,   1'b0);
      chk({tag, ".busy"}, o_busy, 1'b0);
      chk({tag, ".rdy"},  o_rdy,  1'b1);
   endtask

   // One full frame on a gapped instance; s[7] is the first bit out.
   task automatic frame(input string tag, input logic [7:0] s, input logic p);
      for (int i = 0; i < FL; i++) begin
         chk({tag, ".sv"},  o_sv,  1'b1);
         chk({tag, ".so"},  o_so,  (i < 8) ? s[7-i] : p);
         chk({tag, ".wd"},  o_wd,  (i == FL-1));
         chk({tag, ".rdy"}, o_rdy, 1'b0);
         tick();
      end
   endtask

   initial begin
      // reset values, asserted from time 0
      #3;
      sel = 0; chk_idle("rst_a");
      sel = 1; chk_idle("rst_b");
      sel = 2; chk_idle("rst_c");
      tick(); rst = 1'b0;
      tick();
      sel = 0; chk_idle("post_rst");

      // MSB first, 0xA5, one gap cycle; data changes after accept are ignored
      a_data = 8'hA5; a_valid = 1'b1;
      tick();
      a_valid = 1'b0; a_data = 8'h00;
      frame("a5", 8'b1010_0101, 1'b0);
      chk("a5_gap.sv",   o_sv,   1'b0);
      chk("a5_gap.so",   o_so,   1'b0);
      chk("a5_gap.rdy",  o_rdy,  1'b0);
      chk("a5_gap.busy", o_busy, 1'b1);
      tick();
      chk_idle("a5_end");

      // no gap, valid held: 0x0F then 0xF0 back-to-back
      sel = 1;
      b_data = 8'h0F; b_valid = 1'b1;
      tick();
      b_data = 8'hF0;
      for (int k = 1; k <= 2*FL; k++) begin
         int j;
         logic [7:0] s;
         j = (k - 1) % FL;
         s = (k <= FL) ? 8'h0F : 8'hF0;
         chk("b2b.sv",  o_sv,  1'b1);
         chk("b2b.so",  o_so,  (j < 8) ? s[7-j] : 1'b0);
         chk("b2b.rdy", o_rdy, (j == FL-1));
         chk("b2b.wd",  o_wd,  (j == FL-1));
         if (k == FL + 1) b_valid = 1'b0;
         tick();
      end
      chk_idle("b2b_end");

      // LSB first, 0x01: the set bit leaves first
      sel = 2;
      c_data = 8'h01; c_valid = 1'b1;
      tick();
      c_valid = 1'b0;
      frame("lsb01", 8'b1000_0000, 1'b1);
      chk("lsb_gap.sv", o_sv, 1'b0);
      tick();
      chk_idle("lsb_end");

      // reset in the middle of a frame takes effect without a clock edge
      sel = 0;
      a_data = 8'hFF; a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("abort.sv", o_sv, 1'b1);
         chk("abort.so", o_so, 1'b1);
         if (i < 3) tick();
      end
      #2 rst = 1'b1;
      #1;
      chk_idle("abort_rst");
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk_idle("abort_after");
      end

`ifdef EVEN_PARITY_EN
      // 0x07 has three ones, so the parity bit is 1
      a_data = 8'h07; a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      frame("par07", 8'b0000_0111, 1'b1);
      tick();
      chk_idle("par_end");
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
